// File: rtl/count4bcd_chain.sv
// rtl/count4bcd_chain.sv - registered multi-digit BCD up-counter with load, sticky overflow and load-error pulse
// Each digit has its own combinational next-state stage; the carry chain resolves within one cycle.

module count4bcd_digit (
  input  logic       i_ena,
  input  logic       i_clr,
  input  logic [3:0] i_q,
  output logic [3:0] o_next_q,
  output logic       o_c_o
);

  logic w_at_nine;

  // Codes above 9 are unreachable, but wrapping them to 0 keeps the stage self-correcting.
  assign w_at_nine = (i_q >= 4'd9);

  always_comb begin
    o_next_q = i_q;
    if (i_clr) begin
      o_next_q = 4'd0;
    end else if (i_ena) begin
      o_next_q = w_at_nine ? 4'd0 : i_q + 4'd1;
    end
  end

  assign o_c_o = i_ena & (i_q == 4'd9);

endmodule

module count4bcd_chain #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ena,
  input  logic                clr,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] q,
  output logic                c_o,
  output logic                ovf,
  output logic                load_err
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0]      r_q;
  logic              r_ovf;
  logic              r_load_err;

  logic [DIGITS:0]   w_carry;
  logic [W-1:0]      w_next_q;
  logic [W-1:0]      w_load_q;
  logic [DIGITS-1:0] w_digit_bad;
  logic              w_wrap;

  assign w_carry[0] = ena;

  generate
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      count4bcd_digit u_digit (
        .i_ena    (w_carry[g]),
        .i_clr    (clr),
        .i_q      (r_q[4*g +: 4]),
        .o_next_q (w_next_q[4*g +: 4]),
        .o_c_o    (w_carry[g+1])
      );

      // Invalid load digits are replaced by 0 so q never holds a non-BCD code.
      assign w_digit_bad[g]      = (load_val[4*g +: 4] > 4'd9);
      assign w_load_q[4*g +: 4]  = w_digit_bad[g] ? 4'd0 : load_val[4*g +: 4];
    end
  endgenerate

  // Carry out of the top digit means every digit is 9 with ena high: this edge wraps.
  assign w_wrap = w_carry[DIGITS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q        <= '0;
      r_ovf      <= 1'b0;
      r_load_err <= 1'b0;
    end else if (clr) begin
      r_q        <= '0;
      r_ovf      <= 1'b0;
      r_load_err <= 1'b0;
    end else if (load) begin
      r_q        <= w_load_q;
      r_load_err <= |w_digit_bad;
    end else begin
      r_q        <= w_next_q;
      r_load_err <= 1'b0;
      if (w_wrap) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign q        = r_q;
  assign c_o      = w_wrap;
  assign ovf      = r_ovf;
  assign load_err = r_load_err;

endmodule

// File: tb/tb_count4bcd_chain.sv
// tb/tb_count4bcd_chain.sv - scoreboard bench for count4bcd_chain against an integer-valued reference model
// Inputs change on the falling edge; outputs are sampled 2 ns after it (c_o) and 1 ns after the rising edge (state).

module tb_count4bcd_chain;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic         clk;
  logic         reset;
  logic         ena;
  logic         clr;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] q;
  logic         c_o;
  logic         ovf;
  logic         load_err;

  count4bcd_chain #(.DIGITS(DIGITS)) dut (
    .clk      (clk),
    .reset    (reset),
    .ena      (ena),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .q        (q),
    .c_o      (c_o),
    .ovf      (ovf),
    .load_err (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic         ovf;
    logic         err;
    logic         co;
  } exp_t;

  exp_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  int m_cnt;
  bit m_ovf;
  bit m_err;
  int m_max;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_cnt = 0;
    m_ovf = 0;
    m_err = 0;
  endtask

  task automatic drive_now(input bit e, input bit c, input bit l, input logic [W-1:0] lv);
    exp_t it;
    int   d;
    int   scale;
    ena      = e;
    clr      = c;
    load     = l;
    load_val = lv;
    it.co    = e && (m_cnt == m_max);
    if (c) begin
      model_reset();
    end else if (l) begin
      m_cnt = 0;
      m_err = 0;
      scale = 1;
      for (int i = 0; i < DIGITS; i++) begin
        d = int'(lv[4*i +: 4]);
        if (d > 9) begin
          m_err = 1;
          d = 0;
        end
        m_cnt += d * scale;
        scale *= 10;
      end
    end else begin
      m_err = 0;
      if (e) begin
        if (m_cnt == m_max) begin
          m_cnt = 0;
          m_ovf = 1;
        end else begin
          m_cnt++;
        end
      end
    end
    it.q   = to_bcd(m_cnt);
    it.ovf = m_ovf;
    it.err = m_err;
    exp_q.push_back(it);
  endtask

  task automatic step(input bit e, input bit c, input bit l, input logic [W-1:0] lv);
    @(negedge clk);
    drive_now(e, c, l, lv);
  endtask

  // Monitor: c_o belongs to the cycle before the edge, state to the cycle after.
  initial begin
    exp_t it;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() != 0) check("c_o", 32'(c_o), 32'(exp_q[0].co));
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        it = exp_q.pop_front();
        check("q", 32'(q), 32'(it.q));
        check("ovf", 32'(ovf), 32'(it.ovf));
        check("load_err", 32'(load_err), 32'(it.err));
      end
    end
  end

  initial begin
    logic [W-1:0] lv;
    int r;
    m_max = 1;
    for (int i = 0; i < DIGITS; i++) m_max *= 10;
    m_max -= 1;
    model_reset();

    reset = 1'b1; ena = 1'b0; clr = 1'b0; load = 1'b0; load_val = '0;
    #1;
    check("reset_q", 32'(q), 0);
    check("reset_ovf", 32'(ovf), 0);
    check("reset_err", 32'(load_err), 0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold_q", 32'(q), 0);
    @(negedge clk);
    reset = 1'b0;

    repeat (12) step(1, 0, 0, '0);

    step(0, 0, 1, 16'h9998);
    repeat (3) step(1, 0, 0, '0);

    step(0, 0, 1, 16'h12A4);
    step(0, 0, 0, '0);
    step(0, 0, 1, 16'h0456);

    step(0, 0, 1, 16'h9999);
    step(1, 0, 0, '0);
    step(1, 1, 1, 16'h5555);

    step(1, 0, 1, 16'h9999);
    step(1, 0, 0, '0);
    step(0, 0, 1, 16'h0340);
    repeat (7) step(1, 0, 0, '0);
    @(posedge clk);
    #3;
    reset = 1'b1; ena = 1'b0; clr = 1'b0; load = 1'b0;
    #1;
    check("async_reset_q", 32'(q), 0);
    check("async_reset_ovf", 32'(ovf), 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    drive_now(1, 0, 0, '0);

    step(0, 0, 1, 16'h0720);
    repeat (5) step(0, 0, 0, '0);
    step(0, 0, 1, 16'h9999);
    repeat (2) step(0, 0, 0, '0);
    step(1, 0, 1, 16'hF9A9);

    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        step($urandom_range(0, 1) == 1, 1, $urandom_range(0, 1) == 1, W'($urandom));
      end else if (r < 15) begin
        if ($urandom_range(0, 1) == 1) begin
          lv = 16'h9990 | W'($urandom_range(0, 9));
        end else begin
          for (int i = 0; i < DIGITS; i++) lv[4*i +: 4] = 4'($urandom_range(0, 11));
        end
        step($urandom_range(0, 1) == 1, 0, 1, lv);
      end else if (r < 80) begin
        step(1, 0, 0, W'($urandom));
      end else begin
        step(0, 0, 0, W'($urandom));
      end
    end

    @(negedge clk);
    ena = 1'b0; clr = 1'b0; load = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check("queue_drained", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
